// File: rtl/pe_operand_sequencer.sv
// pe_operand_sequencer
// Collects KSIZE pixel/weight pairs into a local buffer and then replays them
// to a processing element (PE) one pair per cycle. It waits PE_LAT drain cycles
// for the PE pipeline, then pulses window_done for one cycle.
// The operand and control outputs come straight from registers, so the PE sees
// stable, glitch-free inputs. in_ready is the only combinational output.

module pe_operand_sequencer #(
    parameter int KSIZE  = 9,
    parameter int PE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_pixel,
    input  logic [15:0] in_weight,
    output logic [15:0] floatA,
    output logic [15:0] floatB,
    output logic        pe_reset,
    output logic        pe_active,
    output logic        window_done
);

    // Counter widths. The drain counter keeps at least one bit so that
    // PE_LAT=0 still elaborates. The buffer index uses the minimum width.
    localparam int KW    = $clog2(KSIZE + 1);
    localparam int DW    = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;
    localparam int IW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int DEPTH = 1 << IW;

    localparam logic [KW-1:0] K_LAST = KW'(KSIZE - 1);
    localparam logic [DW-1:0] D_LAST = DW'((PE_LAT > 0) ? (PE_LAT - 1) : 0);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state_r;
    logic [KW-1:0]  load_cnt_r;
    logic [KW-1:0]  stream_cnt_r;
    logic [DW-1:0]  drain_cnt_r;
    logic [15:0]    float_a_r;
    logic [15:0]    float_b_r;
    logic           pe_reset_r;
    logic           pe_active_r;
    logic           window_done_r;

    logic [15:0]    pix_buf_r [DEPTH];
    logic [15:0]    wgt_buf_r [DEPTH];

    logic           in_ready_s;
    logic           accept_s;
    logic [IW-1:0]  load_idx_s;
    logic [IW-1:0]  next_idx_s;
    logic [15:0]    first_pix_s;
    logic [15:0]    first_wgt_s;

    // Handshake and buffer addressing. A flush blocks acceptance in the same cycle.
    always_comb begin
        in_ready_s = (state_r == LOAD) && !flush;
        accept_s   = in_valid && in_ready_s;
        load_idx_s = IW'(load_cnt_r);
        next_idx_s = IW'(stream_cnt_r + KW'(1));
    end

    // Pair 0 of the window. With a single-pair window it is the pair accepted
    // on this very edge, so it bypasses the buffer.
    always_comb begin
        if (KSIZE == 1) begin
            first_pix_s = in_pixel;
            first_wgt_s = in_weight;
        end else begin
            first_pix_s = pix_buf_r[0];
            first_wgt_s = wgt_buf_r[0];
        end
    end

    // Operand buffer write. The buffer has no reset because each slot is
    // rewritten before it is replayed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            pix_buf_r[load_idx_s] <= in_pixel;
            wgt_buf_r[load_idx_s] <= in_weight;
        end
    end

    // Window sequencing FSM. The outputs are registered, and each one is set
    // together with the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= LOAD;
            load_cnt_r    <= {KW{1'b0}};
            stream_cnt_r  <= {KW{1'b0}};
            drain_cnt_r   <= {DW{1'b0}};
            float_a_r     <= 16'h0000;
            float_b_r     <= 16'h0000;
            pe_reset_r    <= 1'b1;
            pe_active_r   <= 1'b0;
            window_done_r <= 1'b0;
        end else if (flush) begin
            state_r       <= LOAD;
            load_cnt_r    <= {KW{1'b0}};
            stream_cnt_r  <= {KW{1'b0}};
            drain_cnt_r   <= {DW{1'b0}};
            float_a_r     <= 16'h0000;
            float_b_r     <= 16'h0000;
            pe_reset_r    <= 1'b1;
            pe_active_r   <= 1'b0;
            window_done_r <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (accept_s) begin
                        if (load_cnt_r == K_LAST) begin
                            load_cnt_r   <= {KW{1'b0}};
                            stream_cnt_r <= {KW{1'b0}};
                            state_r      <= STREAM;
                            float_a_r    <= first_pix_s;
                            float_b_r    <= first_wgt_s;
                            pe_reset_r   <= 1'b0;
                            pe_active_r  <= 1'b1;
                        end else begin
                            load_cnt_r <= load_cnt_r + KW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (stream_cnt_r == K_LAST) begin
                        stream_cnt_r <= {KW{1'b0}};
                        float_a_r    <= 16'h0000;
                        float_b_r    <= 16'h0000;
                        pe_active_r  <= 1'b0;
                        if (PE_LAT == 0) begin
                            state_r       <= DONE;
                            window_done_r <= 1'b1;
                        end else begin
                            drain_cnt_r <= {DW{1'b0}};
                            state_r     <= DRAIN;
                        end
                    end else begin
                        stream_cnt_r <= stream_cnt_r + KW'(1);
                        float_a_r    <= pix_buf_r[next_idx_s];
                        float_b_r    <= wgt_buf_r[next_idx_s];
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == D_LAST) begin
                        drain_cnt_r   <= {DW{1'b0}};
                        state_r       <= DONE;
                        window_done_r <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DW'(1);
                    end
                end
                DONE: begin
                    state_r       <= LOAD;
                    window_done_r <= 1'b0;
                    pe_reset_r    <= 1'b1;
                end
                default: begin
                    state_r       <= LOAD;
                    load_cnt_r    <= {KW{1'b0}};
                    stream_cnt_r  <= {KW{1'b0}};
                    drain_cnt_r   <= {DW{1'b0}};
                    float_a_r     <= 16'h0000;
                    float_b_r     <= 16'h0000;
                    pe_reset_r    <= 1'b1;
                    pe_active_r   <= 1'b0;
                    window_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_s;
    assign floatA      = float_a_r;
    assign floatB      = float_b_r;
    assign pe_reset    = pe_reset_r;
    assign pe_active   = pe_active_r;
    assign window_done = window_done_r;

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Testbench for pe_operand_sequencer.
// Instance A uses the default sizing (KSIZE=9, PE_LAT=2).
// Instance B is the minimal corner (KSIZE=1, PE_LAT=0).
// Expected values come from the bench's own record of the pairs it offered
// while the sequencer was loading, and from the window timing rules:
// the pairs stream back in order, the pipeline drains, then done pulses.
// An idealised PE accumulates the streamed products in real arithmetic.

module tb_pe_operand_sequencer;

    localparam int KA = 9;
    localparam int LA = 2;

    logic        clk;
    logic        reset;

    logic        a_flush, a_valid, a_ready, a_per, a_act, a_done;
    logic [15:0] a_pix, a_wgt, a_fa, a_fb;

    logic        b_flush, b_valid, b_ready, b_per, b_act, b_done;
    logic [15:0] b_pix, b_wgt, b_fa, b_fb;

    int          n_checks;
    int          n_fail;
    logic [15:0] q_pix[$];
    logic [15:0] q_wgt[$];
    real         pe_acc;

    pe_operand_sequencer #(.KSIZE(KA), .PE_LAT(LA)) dut_a (
        .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_valid),
        .in_ready(a_ready), .in_pixel(a_pix), .in_weight(a_wgt),
        .floatA(a_fa), .floatB(a_fb), .pe_reset(a_per), .pe_active(a_act),
        .window_done(a_done)
    );

    pe_operand_sequencer #(.KSIZE(1), .PE_LAT(0)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_valid),
        .in_ready(b_ready), .in_pixel(b_pix), .in_weight(b_wgt),
        .floatA(b_fa), .floatB(b_fb), .pe_reset(b_per), .pe_active(b_act),
        .window_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real h2r(input logic [15:0] h);
        real r;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) begin
            r = real'(h[9:0]);
            e = 1;
        end else begin
            r = real'({1'b1, h[9:0]});
        end
        for (int i = 0; i < 25; i++) r = r / 2.0;
        for (int i = 0; i < e; i++) r = r * 2.0;
        if (h[15]) r = -r;
        return r;
    endfunction

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h[15]    = 1'($urandom);
        h[14:10] = 5'($urandom_range(20, 10));
        h[9:0]   = 10'($urandom);
        return h;
    endfunction

    // Idealised PE attached to instance A: it clears on pe_reset and
    // accumulates each active product.
    always @(posedge clk or negedge reset) begin
        if (!reset)
            pe_acc <= 0.0;
        else if (a_per)
            pe_acc <= 0.0;
        else if (a_act)
            pe_acc <= pe_acc + h2r(a_fa) * h2r(a_fb);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer pairs to A until n of them are taken, and record each one.
    // mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random gaps.
    task automatic drive_load(input int n, input int mode, input bit fixed);
        int          got;
        int          cyc;
        bit          v;
        logic [35:0] obs;
        logic [35:0] expv;
        got = 0;
        cyc = 0;
        q_pix.delete();
        q_wgt.delete();
        while (got < n) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = 1'($urandom);
            endcase
            a_valid = v;
            a_flush = 1'b0;
            a_pix   = fixed ? 16'h4000 : rand_half();
            a_wgt   = fixed ? 16'h4200 : rand_half();
            #1;
            obs  = {a_ready, a_per, a_act, a_done, a_fa, a_fb};
            expv = {4'b1100, 32'h0};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL load_cycle %0d: observed %h expected %h", cyc, obs, expv);
            end
            if (v) begin
                q_pix.push_back(a_pix);
                q_wgt.push_back(a_wgt);
                got++;
            end
            tick();
            cyc++;
        end
        a_valid = 1'b0;
    endtask

    // Check every cycle after the last acceptance, while offering junk input.
    // Optional flush in cycle flush_at. If stop_at is reached, the task returns
    // in that cycle without advancing.
    task automatic run_window(input int flush_at, input int stop_at);
        real         exp_sum;
        int          last;
        logic [35:0] obs;
        logic [35:0] expv;
        last    = KA + LA + 1;
        exp_sum = 0.0;
        foreach (q_pix[i]) exp_sum = exp_sum + h2r(q_pix[i]) * h2r(q_wgt[i]);
        for (int j = 1; j <= last; j++) begin
            a_valid = 1'($urandom);
            a_pix   = rand_half();
            a_wgt   = rand_half();
            a_flush = (j == flush_at);
            #1;
            if (j <= KA)
                expv = {4'b0010, q_pix[j-1], q_wgt[j-1]};
            else if (j <= KA + LA)
                expv = {4'b0000, 32'h0};
            else
                expv = {4'b0001, 32'h0};
            obs = {a_ready, a_per, a_act, a_done, a_fa, a_fb};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL window_cycle %0d: observed %h expected %h", j, obs, expv);
            end
            if (j == last) begin
                n_checks++;
                if (pe_acc != exp_sum) begin
                    n_fail++;
                    $display("FAIL pe_sum: observed %f expected %f", pe_acc, exp_sum);
                end
            end
            if (j == stop_at) begin
                a_valid = 1'b0;
                a_flush = 1'b0;
                return;
            end
            tick();
            if (j == flush_at) break;
        end
        a_valid = 1'b0;
        a_flush = 1'b0;
        #1;
        obs  = {a_ready, a_per, a_act, a_done, a_fa, a_fb};
        expv = {4'b1100, 32'h0};
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL back_to_load: observed %h expected %h", obs, expv);
        end
    endtask

    task automatic test_reset();
        logic [35:0] obs_a;
        logic [35:0] obs_b;
        reset = 1'b0;
        a_flush = 1'b0; a_valid = 1'b0; a_pix = 16'h0; a_wgt = 16'h0;
        b_flush = 1'b0; b_valid = 1'b0; b_pix = 16'h0; b_wgt = 16'h0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'($urandom);
            a_pix   = rand_half();
            #7;
            obs_a = {a_ready, a_per, a_act, a_done, a_fa, a_fb};
            obs_b = {b_ready, b_per, b_act, b_done, b_fa, b_fb};
            n_checks++;
            if (obs_a !== {4'b1100, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_a: observed %h expected %h", obs_a, {4'b1100, 32'h0});
            end
            n_checks++;
            if (obs_b !== {4'b1100, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_b: observed %h expected %h", obs_b, {4'b1100, 32'h0});
            end
        end
        a_valid = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        drive_load(KA, 0, 1'b1);
        run_window(0, KA + LA + 1);
        n_checks++;
        if (pe_acc != h2r(16'h52C0)) begin
            n_fail++;
            $display("FAIL pe_result_54: observed %f expected %f", pe_acc, h2r(16'h52C0));
        end
        tick();
        drive_load(KA, 0, 1'b0);
        run_window(0, 99);
    endtask

    task automatic test_gapped();
        for (int w = 0; w < 2; w++) begin
            drive_load(KA, 1, 1'b0);
            run_window(0, 99);
        end
    endtask

    task automatic test_random_windows();
        for (int w = 0; w < 4; w++) begin
            drive_load(KA, 2, 1'b0);
            run_window(0, 99);
        end
    endtask

    task automatic test_flush_stream();
        logic [35:0] obs;
        drive_load(KA, 2, 1'b0);
        run_window(5, 99);
        for (int i = 0; i < KA + LA + 2; i++) begin
            tick();
            obs = {a_ready, a_per, a_act, a_done, a_fa, a_fb};
            n_checks++;
            if (obs !== {4'b1100, 32'h0}) begin
                n_fail++;
                $display("FAIL idle_after_flush %0d: observed %h expected %h", i, obs, {4'b1100, 32'h0});
            end
        end
        drive_load(KA, 0, 1'b0);
        run_window(0, 99);
    endtask

    task automatic test_flush_done();
        drive_load(KA, 0, 1'b0);
        run_window(KA + LA + 1, 99);
        drive_load(KA, 2, 1'b0);
        run_window(0, 99);
    endtask

    task automatic test_flush_load();
        logic [35:0] obs;
        drive_load(4, 0, 1'b0);
        a_valid = 1'b1;
        a_flush = 1'b1;
        a_pix   = rand_half();
        a_wgt   = rand_half();
        #1;
        obs = {a_ready, a_per, a_act, a_done, a_fa, a_fb};
        n_checks++;
        if (obs !== {4'b0100, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_in_load: observed %h expected %h", obs, {4'b0100, 32'h0});
        end
        tick();
        a_flush = 1'b0;
        a_valid = 1'b0;
        drive_load(KA, 2, 1'b0);
        run_window(0, 99);
    endtask

    task automatic test_reset_drain();
        logic [35:0] obs;
        drive_load(KA, 0, 1'b0);
        run_window(0, KA + 2);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            obs = {a_ready, a_per, a_act, a_done, a_fa, a_fb};
            n_checks++;
            if (obs !== {4'b1100, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_in_drain %0d: observed %h expected %h", i, obs, {4'b1100, 32'h0});
            end
            tick();
        end
        reset = 1'b1;
        #1;
        obs = {a_ready, a_per, a_act, a_done, a_fa, a_fb};
        n_checks++;
        if (obs !== {4'b1100, 32'h0}) begin
            n_fail++;
            $display("FAIL after_reset_release: observed %h expected %h", obs, {4'b1100, 32'h0});
        end
        drive_load(KA, 2, 1'b0);
        run_window(0, 99);
    endtask

    task automatic test_k1();
        logic [15:0] p;
        logic [15:0] w;
        logic [35:0] obs;
        for (int n = 0; n < 6; n++) begin
            if (1'($urandom)) begin
                b_valid = 1'b0;
                b_pix   = rand_half();
                #1;
                obs = {b_ready, b_per, b_act, b_done, b_fa, b_fb};
                n_checks++;
                if (obs !== {4'b1100, 32'h0}) begin
                    n_fail++;
                    $display("FAIL k1_idle %0d: observed %h expected %h", n, obs, {4'b1100, 32'h0});
                end
                tick();
            end
            p = rand_half();
            w = rand_half();
            b_valid = 1'b1;
            b_pix   = p;
            b_wgt   = w;
            #1;
            obs = {b_ready, b_per, b_act, b_done, b_fa, b_fb};
            n_checks++;
            if (obs !== {4'b1100, 32'h0}) begin
                n_fail++;
                $display("FAIL k1_load %0d: observed %h expected %h", n, obs, {4'b1100, 32'h0});
            end
            tick();
            b_valid = 1'($urandom);
            b_pix   = rand_half();
            b_wgt   = rand_half();
            #1;
            obs = {b_ready, b_per, b_act, b_done, b_fa, b_fb};
            n_checks++;
            if (obs !== {4'b0010, p, w}) begin
                n_fail++;
                $display("FAIL k1_stream %0d: observed %h expected %h", n, obs, {4'b0010, p, w});
            end
            tick();
            #1;
            obs = {b_ready, b_per, b_act, b_done, b_fa, b_fb};
            n_checks++;
            if (obs !== {4'b0001, 32'h0}) begin
                n_fail++;
                $display("FAIL k1_done %0d: observed %h expected %h", n, obs, {4'b0001, 32'h0});
            end
            tick();
            b_valid = 1'b0;
        end
        #1;
        obs = {b_ready, b_per, b_act, b_done, b_fa, b_fb};
        n_checks++;
        if (obs !== {4'b1100, 32'h0}) begin
            n_fail++;
            $display("FAIL k1_return: observed %h expected %h", obs, {4'b1100, 32'h0});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_random_windows();
        test_flush_stream();
        test_flush_done();
        test_flush_load();
        test_reset_drain();
        test_k1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pe_operand_sequencer.md
PE_OPERAND_SEQUENCER -- requirements
Module: pe_operand_sequencer

Interface
REQ-001 Parameter KSIZE, default 9: number of pixel/weight pairs per convolution window, legal range 1..64.
REQ-002 Parameter PE_LAT, default 2: drain cycles after the last operand before the PE result is valid, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous abort; discards the current window.
REQ-006 in_valid  input  1  in_pixel/in_weight pair offered.
REQ-007 in_ready  output  1  sequencer accepts a pair this cycle.
REQ-008 in_pixel  input  16  IEEE half-precision pixel value.
REQ-009 in_weight  input  16  IEEE half-precision weight value.
REQ-010 floatA  output  16  pixel operand to the processing element.
REQ-011 floatB  output  16  weight operand to the processing element.
REQ-012 pe_reset  output  1  active-high accumulator clear to the processing element.
REQ-013 pe_active  output  1  floatA/floatB carry a real operand pair this cycle.
REQ-014 window_done  output  1  one-cycle pulse; PE result is valid this cycle.

Function
REQ-015 The FSM SHALL have exactly four states, LOAD, STREAM, DRAIN and DONE. Outputs are Moore, decoded from the state and from registered data.
REQ-016 A pair SHALL be accepted on a rising edge when in_valid=1 and in_ready=1, and written to buffer slot load_cnt. load_cnt then increments.
REQ-017 in_ready SHALL equal (state==LOAD) AND NOT flush.
REQ-018 When the KSIZE-th pair is accepted, the next state SHALL be STREAM and load_cnt SHALL return to 0.
REQ-019 Gaps in in_valid during LOAD SHALL stall loading without losing already accepted pairs.
REQ-020 In STREAM cycle i (i=0..KSIZE-1): floatA=pixel[i], floatB=weight[i], pe_active=1, pe_reset=0. After cycle KSIZE-1 the FSM SHALL go to DRAIN, or to DONE if PE_LAT=0.
REQ-021 In DRAIN, floatA=floatB=16'h0000, pe_active=0 and pe_reset=0, for exactly PE_LAT cycles; the FSM then goes to DONE.
REQ-022 In DONE, window_done=1 and pe_reset=0 for exactly one cycle, with floatA=floatB=0. The next state SHALL be LOAD.
REQ-023 In LOAD, pe_reset=1, pe_active=0 and floatA=floatB=16'h0000.
REQ-024 Latency: if the last pair is accepted at edge E, window_done SHALL be high in cycle KSIZE+PE_LAT+1 after E.
REQ-025 in_valid outside LOAD SHALL be ignored: no buffer write and no counter change.
REQ-026 flush=1 in any state SHALL force the next state to LOAD and clear all counters. No pair is accepted in that cycle.
REQ-027 A flush in DONE SHALL NOT suppress the window_done pulse already present in that cycle.
REQ-028 Counters SHALL be sized ceil(log2(KSIZE+1)) and ceil(log2(PE_LAT+1)) bits and SHALL never wrap past their terminal counts.

Reset
REQ-029 While reset=0: state=LOAD, all counters=0, floatA=floatB=16'h0000, pe_reset=1, pe_active=0, window_done=0, in_ready=1.
REQ-030 Assertion of reset mid-window SHALL take effect immediately without waiting for a clock edge, and SHALL discard partially loaded or streamed data.
REQ-031 Buffer contents need no reset. They are never output before being rewritten.

Verification
REQ-032 Back-to-back load, with KSIZE=9, PE_LAT=2, nine pairs (4000,4200), in_valid held at 1:
- STREAM shows nine cycles of floatA=4000 and floatB=4200 with pe_active=1.
- window_done is high exactly 12 cycles after the 9th acceptance.
- The PE result equals 54.0, i.e. 16'h52C0.
REQ-033 Gapped load, with in_valid toggling every other cycle: the buffered order is preserved, STREAM presents pairs 0..8 in order, and in_ready=0 throughout STREAM, DRAIN and DONE.
REQ-034 Flush at STREAM cycle 4:
- The next cycle shows state LOAD, pe_reset=1 and no window_done.
- Reloading 9 pairs then yields a correct fresh window.
REQ-035 Reset asserted at DRAIN cycle 1: outputs immediately take the REQ-029 values, and no window_done occurs.
REQ-036 KSIZE=1, PE_LAT=0: one accepted pair gives one STREAM cycle, and window_done follows in the very next cycle.
REQ-037 in_valid=1 together with flush=1 in LOAD: the pair is not accepted, and load_cnt stays at 0.
